// File: rtl/quantum_scheduler.sv
// Preemption timer: counts retired instructions against a programmable quantum and
// raises a held preemption request on expiry; also provides a free-running cycle counter.
module quantum_scheduler #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_inst,
  input  logic                  enable,
  input  logic                  set_quantum,
  input  logic [DATA_WIDTH-1:0] quantum_in,
  input  logic                  time_clear,
  input  logic                  preempt_ack,
  output logic                  preempt_req,
  output logic [DATA_WIDTH-1:0] quantum_out,
  output logic [DATA_WIDTH-1:0] remaining,
  output logic [DATA_WIDTH-1:0] time_out,
  output logic [1:0]            state_out
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StPend = 2'b10
  } state_e;

  state_e state_q;

  assign state_out = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      preempt_req <= 1'b0;
      quantum_out <= '0;
      remaining   <= '0;
      time_out    <= '0;
    end else begin
      time_out <= time_clear ? '0 : time_out + DATA_WIDTH'(1);
      if (set_quantum) quantum_out <= quantum_in;

      unique case (state_q)
        StIdle: begin
          // A same-cycle load defers entry so RUN starts from the new quantum.
          if (enable && !set_quantum && (quantum_out != '0)) begin
            state_q   <= StRun;
            remaining <= quantum_out;
          end
        end
        StRun: begin
          if (!enable) begin
            state_q <= StIdle;
          end else if (set_quantum) begin
            if (quantum_in == '0) begin
              state_q   <= StIdle;
              remaining <= '0;
            end else begin
              remaining <= quantum_in;
            end
          end else if (done_inst) begin
            if (remaining == DATA_WIDTH'(1)) begin
              state_q     <= StPend;
              preempt_req <= 1'b1;
              remaining   <= '0;
            end else begin
              remaining <= remaining - DATA_WIDTH'(1);
            end
          end
        end
        StPend: begin
          if (preempt_ack) begin
            state_q     <= StIdle;
            preempt_req <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          preempt_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quantum_scheduler.sv
// Self-checking bench for quantum_scheduler: directed scenarios then random stimulus
// against an abstract model; a narrow second instance exercises time counter wrap.
module tb_quantum_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_inst, enable, set_quantum, time_clear, preempt_ack;
  logic [31:0] quantum_in;
  logic        preempt_req;
  logic [31:0] quantum_out, remaining, time_out;
  logic [1:0]  state_out;

  logic        s_req;
  logic [7:0]  s_q, s_rem, s_time;
  logic [1:0]  s_state;
  logic [7:0]  s_quantum_in;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_time, m_q, m_rem;
  logic [7:0]  m_t8;
  bit          running, pending;

  always #5 clk = ~clk;

  quantum_scheduler #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .done_inst(done_inst), .enable(enable),
    .set_quantum(set_quantum), .quantum_in(quantum_in), .time_clear(time_clear),
    .preempt_ack(preempt_ack), .preempt_req(preempt_req), .quantum_out(quantum_out),
    .remaining(remaining), .time_out(time_out), .state_out(state_out)
  );

  quantum_scheduler #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .done_inst(1'b0), .enable(1'b0), .set_quantum(1'b0),
    .quantum_in(s_quantum_in), .time_clear(1'b0), .preempt_ack(1'b0),
    .preempt_req(s_req), .quantum_out(s_q), .remaining(s_rem), .time_out(s_time),
    .state_out(s_state)
  );

  assign s_quantum_in = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_time = 0; m_q = 0; m_rem = 0; m_t8 = 0;
    running = 0; pending = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      m_time = time_clear ? 32'd0 : m_time + 32'd1;
      m_t8   = m_t8 + 8'd1;
      if (pending) begin
        if (preempt_ack) pending = 0;
      end else if (running) begin
        if (!enable) running = 0;
        else if (set_quantum) begin
          if (quantum_in == 0) begin running = 0; m_rem = 0; end
          else m_rem = quantum_in;
        end else if (done_inst) begin
          if (m_rem == 1) begin running = 0; pending = 1; m_rem = 0; end
          else m_rem = m_rem - 1;
        end
      end else if (enable && !set_quantum && m_q != 0) begin
        running = 1;
        m_rem   = m_q;
      end
      if (set_quantum) m_q = quantum_in;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, {30'd0, state_out}, pending ? 32'd2 : (running ? 32'd1 : 32'd0));
    check({tag, ".req"}, {31'd0, preempt_req}, {31'd0, pending});
    check({tag, ".rem"}, remaining, m_rem);
    check({tag, ".quantum"}, quantum_out, m_q);
    check({tag, ".time"}, time_out, m_time);
    check({tag, ".time8"}, {24'd0, s_time}, {24'd0, m_t8});
  endtask

  // Apply inputs (called just after a negedge), clock once, check at the next negedge.
  task automatic drive(input string tag, input logic d, input logic e, input logic s,
                       input logic [31:0] q, input logic c, input logic a);
    done_inst = d; enable = e; set_quantum = s; quantum_in = q; time_clear = c;
    preempt_ack = a;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    done_inst = 0; enable = 0; set_quantum = 0; quantum_in = 0; time_clear = 0;
    preempt_ack = 0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Reset mid-count, checked without a clock edge
    drive("ld5", 0, 1, 1, 5, 0, 0);
    drive("run5", 0, 1, 0, 0, 0, 0);
    check("run5.rem_is5", remaining, 32'd5);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    drive("rst_hold", 0, 1, 0, 0, 0, 0);
    rst = 1'b0;

    // Quantum of 3 runs down to a preemption request
    drive("ld3", 0, 1, 1, 3, 0, 0);
    drive("run3", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive("done", 1, 1, 0, 0, 0, 0);
    check("pend.req", {31'd0, preempt_req}, 32'd1);

    // PEND ignores done_inst until acknowledged
    for (int i = 0; i < 4; i++) drive("pend_done", 1, 1, 0, 0, 0, 0);
    check("pend.rem0", remaining, 32'd0);
    drive("ack", 0, 1, 0, 0, 0, 1);
    check("ack.idle", {30'd0, state_out}, 32'd0);
    drive("rerun", 0, 1, 0, 0, 0, 0);
    check("rerun.rem3", remaining, 32'd3);

    // Reload mid-run beats a same-cycle done_inst; zero quantum stops
    drive("to2", 1, 1, 0, 0, 0, 0);
    drive("set10", 1, 1, 1, 10, 0, 0);
    check("set10.rem", remaining, 32'd10);
    drive("set0", 0, 1, 1, 0, 0, 0);
    check("set0.idle", {30'd0, state_out}, 32'd0);

    // Enable drop keeps remaining; re-entry reloads from the quantum register
    drive("ld6", 0, 1, 1, 6, 0, 0);
    drive("run6", 0, 1, 0, 0, 0, 0);
    drive("to5", 1, 1, 0, 0, 0, 0);
    drive("to4", 1, 1, 0, 0, 0, 0);
    drive("dis", 1, 0, 0, 0, 0, 0);
    check("dis.rem4", remaining, 32'd4);
    drive("reen", 0, 1, 0, 0, 0, 0);
    check("reen.rem6", remaining, 32'd6);

    // time_clear at 100
    for (int i = 0; i < 200 && m_time != 32'd100; i++) drive("tick", 0, 0, 0, 0, 0, 0);
    check("time100", time_out, 32'd100);
    drive("tclr", 0, 0, 0, 0, 1, 0);
    check("tclr.zero", time_out, 32'd0);
    drive("tclr_next", 0, 0, 0, 0, 0, 0);
    check("tclr.one", time_out, 32'd1);

    // Narrow instance wraps all-ones to zero
    for (int i = 0; i < 300 && m_t8 != 8'hff; i++) drive("tick8", 0, 0, 0, 0, 0, 0);
    check("t8.ones", {24'd0, s_time}, 32'h0000_00ff);
    drive("wrap8", 0, 0, 0, 0, 0, 0);
    check("t8.wrap", {24'd0, s_time}, 32'd0);

    // Random phase
    for (int i = 0; i < 500; i++) begin
      drive("rand",
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 9) != 0),
            logic'($urandom_range(0, 9) == 0),
            32'($urandom_range(0, 6)),
            logic'($urandom_range(0, 29) == 0),
            logic'($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
